// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI master arbiter: state encoding,
// start timeout and the round-robin search used by the picker.
package spi_arb_pkg;

  typedef enum logic [3:0] {
    ARB_IDLE  = 4'b0001,
    ARB_START = 4'b0010,
    ARB_BUSY  = 4'b0100,
    ARB_DONE  = 4'b1000
  } arb_state_e;

  localparam int START_TIMEOUT = 15;
  localparam int MAX_REQ       = 8;

  // Searches last+1, last+2, ... modulo n; the nearest set request wins.
  // Iterating from the far end lets the nearest candidate overwrite the rest.
  function automatic logic rr_next(
    input  int                 last,
    input  logic [MAX_REQ-1:0] req_vec,
    input  int                 n,
    output int                 idx
  );
    logic found;
    int   cand;
    found = 1'b0;
    idx   = 0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      cand = (last + k) % n;
      if ((k <= n) && (((req_vec >> cand) & MAX_REQ'(1)) != '0)) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: given the request vector and the last
// winner, returns the next winner index and whether any request is pending.
module spi_rr_picker
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               winner_valid
);

  logic [MAX_REQ-1:0] req_ext;
  logic               pick_valid;
  int                 pick_idx;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_REQ; gi++) begin : g_ext
      if (gi < NUM_REQ) begin : g_in
        assign req_ext[gi] = req[gi];
      end else begin : g_pad
        assign req_ext[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    pick_idx     = 0;
    pick_valid   = rr_next(int'(last_winner), req_ext, NUM_REQ, pick_idx);
    winner_valid = pick_valid && (pick_idx < NUM_REQ);
    winner_idx   = IDX_W'(pick_idx);
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one SPI master between NUM_REQ requesters: latches
// the winner's word, strobes start, steers ss_n and returns a done pulse.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done_out,
  output logic                      m_start,
  output logic [DATA_W-1:0]         m_data,
  input  logic                      m_idle,
  input  logic                      m_ss_n,
  output logic [NUM_REQ-1:0]        ss_n_out,
  output logic                      busy,
  output logic [IDX_W-1:0]          owner_idx
);

  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_reg, state_next;
  logic [3:0]         start_cnt_reg, start_cnt_next;
  logic [IDX_W-1:0]   last_winner_reg, last_winner_next;
  logic [IDX_W-1:0]   owner_idx_reg, owner_idx_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [NUM_REQ-1:0] ss_n_reg, ss_n_next;
  logic [DATA_W-1:0]  m_data_reg, m_data_next;
  logic               m_start_reg, m_start_next;
  logic               err_reg, err_next;
  logic               start_timeout;
  logic               in_transfer_next;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic [DATA_W-1:0]  req_word [NUM_REQ];

  spi_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req          (req),
    .last_winner  (last_winner_reg),
    .winner_idx   (win_idx),
    .winner_valid (win_valid)
  );

  // Only the owner's select line follows the master; everyone else stays high.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign req_word[gi]  = req_data[gi*DATA_W +: DATA_W];
      assign ss_n_next[gi] = (in_transfer_next && grant_next[gi]) ? m_ss_n : 1'b1;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    start_timeout = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (win_valid && m_idle) state_next = ARB_START;
      end
      ARB_START: begin
        if (!m_idle) begin
          state_next = ARB_BUSY;
        end else if (start_cnt_reg == 4'(START_TIMEOUT)) begin
          state_next    = ARB_DONE;
          start_timeout = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (m_idle) state_next = ARB_DONE;
      end
      ARB_DONE: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_next       = grant_reg;
    owner_idx_next   = owner_idx_reg;
    m_data_next      = m_data_reg;
    last_winner_next = last_winner_reg;
    done_next        = '0;
    start_cnt_next   = '0;
    m_start_next     = (state_next == ARB_START);
    err_next         = err_reg | start_timeout;
    in_transfer_next = (state_next == ARB_START) || (state_next == ARB_BUSY);
    if (state_reg == ARB_START) start_cnt_next = start_cnt_reg + 4'd1;
    if ((state_reg == ARB_IDLE) && (state_next == ARB_START)) begin
      grant_next     = NUM_REQ'(1) << win_idx;
      owner_idx_next = win_idx;
      m_data_next    = req_word[win_idx];
    end
    if (state_reg == ARB_DONE) last_winner_next = owner_idx_reg;
    if (state_next == ARB_IDLE) grant_next = '0;
    if (state_next == ARB_DONE) done_next = NUM_REQ'(1) << owner_idx_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_cnt_reg   <= '0;
      last_winner_reg <= LAST_INIT;
      owner_idx_reg   <= '0;
      grant_reg       <= '0;
      done_reg        <= '0;
      ss_n_reg        <= '1;
      m_data_reg      <= '0;
      m_start_reg     <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      start_cnt_reg   <= start_cnt_next;
      last_winner_reg <= last_winner_next;
      owner_idx_reg   <= owner_idx_next;
      grant_reg       <= grant_next;
      done_reg        <= done_next;
      ss_n_reg        <= ss_n_next;
      m_data_reg      <= m_data_next;
      m_start_reg     <= m_start_next;
      err_reg         <= err_next;
    end
  end

  assign grant     = grant_reg;
  assign done_out  = done_reg;
  assign m_start   = m_start_reg;
  assign m_data    = m_data_reg;
  assign ss_n_out  = ss_n_reg;
  assign busy      = (state_reg != ARB_IDLE);
  assign owner_idx = owner_idx_reg;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter: stimulus queues expected grants and
// completions, a negedge monitor pops and compares them as the DUT shows them.
module tb_spi_master_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 16;
  localparam int IDX_W      = 2;
  localparam int MASTER_LEN = 40;

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          start_cyc;
    bit          owner_low;
    bit          gap_chk;
  } exp_t;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        grant, done_out, ss_n_out;
  logic                      m_start, busy;
  logic [DATA_W-1:0]         m_data;
  logic                      m_idle = 1'b1;
  logic                      m_ss_n = 1'b1;
  logic [IDX_W-1:0]          owner_idx;

  logic [15:0] words [4] = '{16'hA55A, 16'h1234, 16'hBEEF, 16'hC3C3};
  exp_t        q_grant[$];
  exp_t        q_done[$];
  int          total = 0;
  int          bad = 0;
  bit          mdl_hang = 1'b0;
  int          bcnt = 0;

  spi_master_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .done_out  (done_out),
    .m_start   (m_start),
    .m_data    (m_data),
    .m_idle    (m_idle),
    .m_ss_n    (m_ss_n),
    .ss_n_out  (ss_n_out),
    .busy      (busy),
    .owner_idx (owner_idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req_v);
    end
  endtask

  // Master model: leaves idle on the first edge that sees start, stays busy
  // MASTER_LEN cycles with ss_n low; in hang mode it never responds.
  always @(posedge clock) begin
    if (reset) begin
      m_idle <= 1'b1;
      m_ss_n <= 1'b1;
      bcnt   <= 0;
    end else if (m_idle) begin
      if (m_start && !mdl_hang) begin
        m_idle <= 1'b0;
        m_ss_n <= 1'b0;
        bcnt   <= MASTER_LEN;
      end
    end else begin
      if (bcnt <= 1) begin
        m_idle <= 1'b1;
        m_ss_n <= 1'b1;
      end
      bcnt <= bcnt - 1;
    end
  end

  // Monitor / scoreboard
  exp_t               ge, de;
  int                 cyc = 0;
  int                 last_done_cyc = 0;
  int                 st_cnt = 0;
  int                 txn = 0;
  bit                 own_low = 0, oth_low = 0, multi = 0;
  logic [NUM_REQ-1:0] prev_grant = '0;

  always @(negedge clock) begin
    if (reset) begin
      st_cnt     = 0;
      own_low    = 0;
      oth_low    = 0;
      multi      = 0;
      prev_grant = '0;
    end else begin
      cyc++;
      if (m_start) st_cnt++;
      if ((grant & (grant - 1'b1)) != '0) multi = 1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!ss_n_out[i]) begin
          if (grant[i]) own_low = 1;
          else          oth_low = 1;
        end
      end
      if (grant != '0 && prev_grant == '0) begin
        if (q_grant.size() == 0) begin
          chk("unexpected_grant", 32'(grant), 0);
        end else begin
          ge = q_grant.pop_front();
          chk("grant", 32'(grant), 32'(1) << ge.idx);
          chk("owner_idx", 32'(owner_idx), 32'(ge.idx));
          chk("m_data_at_grant", 32'(m_data), 32'(ge.data));
          if (ge.gap_chk) chk("idle_gap", 32'(cyc - last_done_cyc), 2);
        end
      end
      if (done_out != '0) begin
        if (q_done.size() == 0) begin
          chk("unexpected_done", 32'(done_out), 0);
        end else begin
          de = q_done.pop_front();
          chk("done_out", 32'(done_out), 32'(1) << de.idx);
          chk("m_data_at_done", 32'(m_data), 32'(de.data));
          chk("start_cycles", 32'(st_cnt), 32'(de.start_cyc));
          chk("owner_ss_low", 32'(own_low), 32'(de.owner_low));
          chk("other_ss_low", 32'(oth_low), 0);
          chk("grant_onehot", 32'(multi), 0);
          $display("txn %0d: owner=%0d data=%h start_cycles=%0d", txn, de.idx, m_data, st_cnt);
        end
        txn++;
        last_done_cyc = cyc;
        st_cnt  = 0;
        own_low = 0;
        oth_low = 0;
        multi   = 0;
      end
      prev_grant = grant;
    end
  end

  task automatic push(input int idx, input int st, input bit low, input bit gap);
    exp_t e;
    e.idx = idx; e.data = words[idx]; e.start_cyc = st; e.owner_low = low; e.gap_chk = gap;
    q_grant.push_back(e);
    q_done.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    req   = '0;
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Returns at #1 after the edge following the n-th done pulse (an idle cycle).
  task automatic wait_done(input int n);
    int seen = 0;
    int b = 0;
    while (seen < n && b < 5000) begin
      @(negedge clock);
      b++;
      if (done_out != '0) seen++;
    end
    chk("wait_done", 32'(seen), 32'(n));
    @(posedge clock); #1;
  endtask

  task automatic wait_busy();
    bit found = 0;
    for (int b = 0; b < 500 && !found; b++) begin
      @(negedge clock);
      if (grant != '0 && !m_idle) found = 1;
    end
    chk("wait_busy", 32'(found), 1);
    @(posedge clock); #1;
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = words[i];
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done_out), 0);
    chk("rst_m_start", 32'(m_start), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_ss_n", 32'(ss_n_out), 32'hF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner_idx), 0);
    chk("rst_err", 32'(dut.err_reg), 0);

    // single transaction to requester 0
    @(posedge clock); #1;
    push(0, 2, 1, 0);
    req = 4'b0001;
    @(negedge clock);
    chk("grant_registered", 32'(grant), 0);
    @(negedge clock);
    chk("grant_next_cycle", 32'(grant), 32'h1);
    wait_done(1);
    req = '0;

    // two requesters alternate
    do_reset();
    push(0, 2, 1, 0); push(2, 2, 1, 1); push(0, 2, 1, 1); push(2, 2, 1, 1);
    req = 4'b0101;
    wait_done(4);
    req = '0;

    // all four requesting
    do_reset();
    for (int t = 0; t < 8; t++) push(t % 4, 2, 1, t != 0);
    req = 4'b1111;
    wait_done(8);
    req = '0;

    // requester 1 drops req and changes data mid-transfer; requester 3 follows
    do_reset();
    push(1, 2, 1, 0); push(3, 2, 1, 1);
    req = 4'b1010;
    wait_busy();
    req[1] = 1'b0;
    req_data[1*DATA_W +: DATA_W] = 16'hFFFF;
    wait_done(2);
    req = '0;
    req_data[1*DATA_W +: DATA_W] = words[1];
    push(1, 2, 1, 0);
    req = 4'b0010;
    wait_busy();
    req = '0;
    wait_done(1);
    repeat (10) @(negedge clock);
    chk("no_regrant", 32'(grant), 0);
    chk("idle_after_drop", 32'(busy), 0);

    // reset in BUSY discards the transaction and restores priority to 0
    do_reset();
    push(1, 2, 1, 0);
    req = 4'b0010;
    wait_done(1);
    req = '0;
    push(2, 2, 1, 0);
    req = 4'b0100;
    wait_busy();
    reset = 1'b1;
    req   = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rstbusy_grant", 32'(grant), 0);
    chk("rstbusy_ss_n", 32'(ss_n_out), 32'hF);
    chk("rstbusy_m_start", 32'(m_start), 0);
    chk("rstbusy_done", 32'(done_out), 0);
    q_done.delete();
    push(0, 2, 1, 0);
    req = 4'b0101;
    wait_done(1);
    req = '0;

    // master never leaves idle: start timeout
    do_reset();
    mdl_hang = 1'b1;
    push(2, 16, 0, 0);
    req = 4'b0100;
    wait_done(1);
    req = '0;
    mdl_hang = 1'b0;
    @(negedge clock);
    chk("timeout_idle", 32'(busy), 0);
    chk("timeout_grant", 32'(grant), 0);
    chk("timeout_err", 32'(dut.err_reg), 1);

    repeat (3) @(negedge clock);
    chk("grant_queue_empty", 32'(q_grant.size()), 0);
    chk("done_queue_empty", 32'(q_done.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
